// File: rtl/conv2d_stream_mc_if.sv
// Pixel-in / feature-out stream bundle for conv2d_stream_mc.
//   in_valid/in_ready/in_pixel/in_sof        : raster-order pixel stream (upstream -> engine)
//   out_valid/out_ready/out_pixels/out_sof/eol/eof : per-window results, NUM_CH samples (engine -> writer)
// slave is the engine side, master is the producer/consumer side.
interface conv2d_stream_mc_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int OUT_W  = 16
);
    logic                           in_valid;
    logic                           in_ready;
    logic signed [DATA_W-1:0]       in_pixel;
    logic                           in_sof;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_CH-1:0][OUT_W-1:0]   out_pixels;
    logic                           out_sof;
    logic                           out_eol;
    logic                           out_eof;

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_pixels, out_sof, out_eol, out_eof
    );
    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_pixels, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/conv2d_stream_mc.sv
// Streaming WIN_SIZE x WIN_SIZE 2D convolution, NUM_CH kernels in parallel.
//   clk, rst        : clock, asynchronous active-low reset
//   cfg_stride2     : stride 2 select, taken on accepted in_sof
//   cfg_relu        : clamp negative sums to 0, taken on accepted in_sof
//   kernel          : [ch][row][col] signed coefficients, taken on accepted in_sof
//   s (slave)       : pixel input stream and result output stream
// Two enabled stages: products, then adder tree + ReLU/saturation into the output regs.

// One output channel: registered products, then sum and post-processing (combinational).
module conv2d_stream_mc_ch #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int WIN_SIZE = 3,
    parameter int SUM_W    = 32,
    parameter int OUT_W    = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         en,
    input  logic                                         relu,
    input  logic [WIN_SIZE*WIN_SIZE-1:0][DATA_W-1:0]     win,
    input  logic [WIN_SIZE*WIN_SIZE-1:0][COEF_W-1:0]     coef,
    output logic [OUT_W-1:0]                             res
);
    localparam int NT = WIN_SIZE * WIN_SIZE;
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [NT-1:0][PW-1:0]   prod_q, prod_d;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        prod_d = prod_q;
        if (en) begin
            for (int k = 0; k < NT; k++) begin
                prod_d[k] = PW'($signed(win[k]) * $signed(coef[k]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prod_q <= '0;
        else      prod_q <= prod_d;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NT; k++) begin
            sum = sum + SUM_W'($signed(prod_q[k]));
        end
        if (relu && (sum < 0))     res = '0;
        else if (sum > SAT_MAX)    res = SAT_MAX[OUT_W-1:0];
        else if (sum < SAT_MIN)    res = SAT_MIN[OUT_W-1:0];
        else                       res = sum[OUT_W-1:0];
    end
endmodule

module conv2d_stream_mc #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int WIN_SIZE = 3,
    parameter int NUM_CH   = 4,
    parameter int SUM_W    = 32,
    parameter int OUT_W    = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   cfg_stride2,
    input  logic                                                   cfg_relu,
    input  logic [NUM_CH-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_W-1:0] kernel,
    conv2d_stream_mc_if.slave                                      s
);
    localparam int NT     = WIN_SIZE * WIN_SIZE;
    localparam int STAGES = 2;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef logic [CW-1:0] col_t;
    typedef logic [RW-1:0] row_t;
    typedef struct packed { logic sof; logic eol; logic eof; } mark_t;
    typedef logic [NUM_CH-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_W-1:0] kern_t;

    localparam col_t COL_MAX   = col_t'(IMG_W - 1);
    localparam row_t ROW_MAX   = row_t'(IMG_H - 1);
    localparam col_t WM1_C     = col_t'(WIN_SIZE - 1);
    localparam row_t WM1_R     = row_t'(WIN_SIZE - 1);
    localparam col_t OW_M1_S1  = col_t'(IMG_W - WIN_SIZE);
    localparam col_t OW_M1_S2  = col_t'((IMG_W - WIN_SIZE) / 2);
    localparam row_t OH_M1_S1  = row_t'(IMG_H - WIN_SIZE);
    localparam row_t OH_M1_S2  = row_t'((IMG_H - WIN_SIZE) / 2);

    logic                         en, acc, emit, s2_eff;
    col_t                         col_q, col_d, pcol, cdiff, ocol;
    row_t                         row_q, row_d, prow, rdiff, orow;
    logic                         stride2_q, stride2_d, relu_q, relu_d;
    kern_t                        kern_q, kern_d;
    logic [STAGES:1]              vld_pipe_q, vld_pipe_d;
    mark_t                        mark_w, mark_s1_q, mark_s1_d, mark_out_q, mark_out_d;
    logic                         relu_s1_q, relu_s1_d;
    logic [NUM_CH-1:0][OUT_W-1:0] out_pix_q, out_pix_d, ch_res;

    // Line buffers and window columns hold data only; validity comes from the counters.
    logic [DATA_W-1:0]            lb_mem [WIN_SIZE-1][IMG_W];
    logic [DATA_W-1:0]            win_q  [WIN_SIZE][WIN_SIZE-1];
    logic [DATA_W-1:0]            vcol   [WIN_SIZE];
    logic [DATA_W-1:0]            wcur   [WIN_SIZE][WIN_SIZE];
    logic [NT-1:0][DATA_W-1:0]    wk;

    // Window assembly: vcol is the incoming column (index 0 = current row),
    // wcur[r][j] is r rows up and j columns left of the current pixel.
    always_comb begin
        for (int r = 0; r < WIN_SIZE; r++) begin
            vcol[r] = (r == 0) ? s.in_pixel : lb_mem[(r == 0) ? 0 : r-1][pcol];
            wcur[r][0] = vcol[r];
            for (int j = 1; j < WIN_SIZE; j++) wcur[r][j] = win_q[r][j-1];
        end
        // Flatten to kernel order: [top row .. bottom row][left col .. right col].
        for (int i = 0; i < WIN_SIZE; i++) begin
            for (int j = 0; j < WIN_SIZE; j++) begin
                wk[i*WIN_SIZE + j] = wcur[WIN_SIZE-1-i][WIN_SIZE-1-j];
            end
        end
    end

    always_comb begin
        en     = !vld_pipe_q[STAGES] || s.out_ready;
        acc    = s.in_valid && en;
        // An in_sof pixel is forced to the origin and sees its own frame's stride.
        s2_eff = s.in_sof ? cfg_stride2 : stride2_q;
        pcol   = s.in_sof ? '0 : col_q;
        prow   = s.in_sof ? '0 : row_q;
        cdiff  = pcol - WM1_C;
        rdiff  = prow - WM1_R;
        ocol   = s2_eff ? (cdiff >> 1) : cdiff;
        orow   = s2_eff ? (rdiff >> 1) : rdiff;
        emit   = (pcol >= WM1_C) && (prow >= WM1_R) && (!s2_eff || (!cdiff[0] && !rdiff[0]));
        mark_w.sof = (ocol == '0) && (orow == '0);
        mark_w.eol = (ocol == (s2_eff ? OW_M1_S2 : OW_M1_S1));
        mark_w.eof = mark_w.eol && (orow == (s2_eff ? OH_M1_S2 : OH_M1_S1));

        col_d      = col_q;
        row_d      = row_q;
        stride2_d  = stride2_q;
        relu_d     = relu_q;
        kern_d     = kern_q;
        vld_pipe_d = vld_pipe_q;
        mark_s1_d  = mark_s1_q;
        mark_out_d = mark_out_q;
        relu_s1_d  = relu_s1_q;
        out_pix_d  = out_pix_q;

        if (acc) begin
            if (pcol == COL_MAX) begin
                col_d = '0;
                row_d = (prow == ROW_MAX) ? '0 : prow + 1'b1;
            end else begin
                col_d = pcol + 1'b1;
                row_d = prow;
            end
            if (s.in_sof) begin
                stride2_d = cfg_stride2;
                relu_d    = cfg_relu;
                kern_d    = kernel;
            end
        end

        if (en) begin
            vld_pipe_d[1] = acc && emit;
            vld_pipe_d[2] = vld_pipe_q[1];
            mark_s1_d     = (acc && emit) ? mark_w : '0;
            relu_s1_d     = s.in_sof ? cfg_relu : relu_q;
            mark_out_d    = vld_pipe_q[1] ? mark_s1_q : '0;
            if (vld_pipe_q[1]) out_pix_d = ch_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            stride2_q  <= 1'b0;
            relu_q     <= 1'b0;
            kern_q     <= '0;
            vld_pipe_q <= '0;
            mark_s1_q  <= '0;
            mark_out_q <= '0;
            relu_s1_q  <= 1'b0;
            out_pix_q  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            stride2_q  <= stride2_d;
            relu_q     <= relu_d;
            kern_q     <= kern_d;
            vld_pipe_q <= vld_pipe_d;
            mark_s1_q  <= mark_s1_d;
            mark_out_q <= mark_out_d;
            relu_s1_q  <= relu_s1_d;
            out_pix_q  <= out_pix_d;
        end
    end

    // Row k of the line buffer holds the row k+1 above the current one.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_mem[0][pcol] <= s.in_pixel;
            for (int k = 1; k < WIN_SIZE-1; k++) lb_mem[k][pcol] <= lb_mem[k-1][pcol];
            for (int r = 0; r < WIN_SIZE; r++) begin
                win_q[r][0] <= vcol[r];
                for (int j = 1; j < WIN_SIZE-1; j++) win_q[r][j] <= win_q[r][j-1];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        conv2d_stream_mc_ch #(
            .DATA_W(DATA_W), .COEF_W(COEF_W), .WIN_SIZE(WIN_SIZE), .SUM_W(SUM_W), .OUT_W(OUT_W)
        ) u_ch (
            .clk(clk), .rst(rst), .en(en), .relu(relu_s1_q),
            .win(wk), .coef(kern_q[g]), .res(ch_res[g])
        );
    end

    assign s.in_ready   = en;
    assign s.out_valid  = vld_pipe_q[STAGES];
    assign s.out_pixels = out_pix_q;
    assign s.out_sof    = mark_out_q.sof;
    assign s.out_eol    = mark_out_q.eol;
    assign s.out_eof    = mark_out_q.eof;
endmodule
